// File: rtl/coord_entry_pkg.sv
// Shared types and helpers for the coordinate-entry block: FSM state encoding,
// a constant-foldable clog2 and one-hot decode helpers.
package coord_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PRESS,
    WAIT_RELEASE,
    DONE
  } state_t;

  // Helpers take a fixed-width vector; callers zero-extend their key vector into it.
  localparam int MAXKEYS = 64;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic logic is_onehot(input logic [MAXKEYS-1:0] v);
    return (v != '0) && ((v & (v - MAXKEYS'(1))) == '0);
  endfunction

  function automatic int onehot_index(input logic [MAXKEYS-1:0] v);
    int idx;
    idx = 0;
    for (int i = 0; i < MAXKEYS; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/coord_entry_if.sv
// Key/control inputs and coordinate/status outputs of coord_entry, bundled
// so the board controller and the entry block share one connection.
interface coord_entry_if #(
  parameter int NKEYS = 4,
  parameter int NAXES = 2
);
  import coord_pkg::*;

  localparam int IDW = clog2(NKEYS);
  localparam int AW  = clog2(NAXES) + 1;

  logic                  start;
  logic                  abort;
  logic [NKEYS-1:0]      keys;
  logic [NAXES*IDW-1:0]  coord;
  logic [AW-1:0]         axis;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (output start, abort, keys, input coord, axis, busy, done, err);
  modport slave  (input start, abort, keys, output coord, axis, busy, done, err);

endinterface

// File: rtl/coord_entry_debounce.sv
// Key-vector debouncer: a new key vector reaches db only after it has been
// seen unchanged on DEBOUNCE consecutive clock edges.
module key_debounce
  import coord_pkg::*;
#(
  parameter int NKEYS    = 4,
  parameter int DEBOUNCE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NKEYS-1:0] keys,
  output logic [NKEYS-1:0] db
);

  localparam int            CW   = clog2(DEBOUNCE) + 1;
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE - 1);

  logic [NKEYS-1:0] cand;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;

  // Counter saturates at CMAX so a long hold never wraps back into a stale window.
  always_comb begin
    cnt_nxt = '0;
    if (keys == cand) cnt_nxt = (cnt == CMAX) ? cnt : cnt + CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cand <= '0;
      cnt  <= '0;
      db   <= '0;
    end else begin
      cand <= keys;
      cnt  <= cnt_nxt;
      if (cnt_nxt == CMAX) db <= keys;
    end
  end

endmodule

// File: rtl/coord_entry.sv
// Keypad coordinate entry: captures NAXES key indices in sequence from
// debounced one-hot keys, rejecting multi-key presses.
module coord_entry
  import coord_pkg::*;
#(
  parameter int NKEYS    = 4,
  parameter int NAXES    = 2,
  parameter int DEBOUNCE = 4
) (
  input  logic         clk,
  input  logic         rst,
  coord_entry_if.slave bus
);

  localparam int            IDW  = clog2(NKEYS);
  localparam int            AW   = clog2(NAXES) + 1;
  localparam logic [AW-1:0] LAST = AW'(NAXES - 1);

  state_t               state, state_nxt;
  logic [AW-1:0]        axis_q, axis_nxt;
  logic [NAXES*IDW-1:0] coord_q, coord_nxt;
  logic                 reject_q, reject_nxt;
  logic [NKEYS-1:0]     db;
  logic [MAXKEYS-1:0]   db_ext;
  logic                 db_onehot;
  logic                 db_multi;

  key_debounce #(.NKEYS(NKEYS), .DEBOUNCE(DEBOUNCE)) u_debounce (
    .clk  (clk),
    .rst  (rst),
    .keys (bus.keys),
    .db   (db)
  );

  always_comb begin
    db_ext            = '0;
    db_ext[NKEYS-1:0] = db;
  end

  assign db_onehot = is_onehot(db_ext);
  assign db_multi  = (db != '0) && !db_onehot;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      axis_q   <= '0;
      coord_q  <= '0;
      reject_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      axis_q   <= axis_nxt;
      coord_q  <= coord_nxt;
      reject_q <= reject_nxt;
    end
  end

  // abort overrides everything, including the done/err pulses of its own cycle.
  always_comb begin
    state_nxt  = state;
    axis_nxt   = axis_q;
    coord_nxt  = coord_q;
    reject_nxt = reject_q;
    bus.done   = 1'b0;
    bus.err    = 1'b0;
    if (bus.abort) begin
      state_nxt  = IDLE;
      reject_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state_nxt  = WAIT_PRESS;
            axis_nxt   = '0;
            reject_nxt = 1'b0;
          end
        end
        WAIT_PRESS: begin
          if (db_onehot) begin
            coord_nxt[int'(axis_q)*IDW +: IDW] = IDW'(onehot_index(db_ext));
            state_nxt = WAIT_RELEASE;
          end else if (db_multi) begin
            bus.err    = 1'b1;
            reject_nxt = 1'b1;
            state_nxt  = WAIT_RELEASE;
          end
        end
        WAIT_RELEASE: begin
          if (db == '0) begin
            if (reject_q) begin
              reject_nxt = 1'b0;
              state_nxt  = WAIT_PRESS;
            end else if (axis_q == LAST) begin
              state_nxt = DONE;
            end else begin
              axis_nxt  = axis_q + AW'(1);
              state_nxt = WAIT_PRESS;
            end
          end
        end
        DONE: begin
          bus.done  = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign bus.busy  = (state != IDLE);
  assign bus.axis  = axis_q;
  assign bus.coord = coord_q;

endmodule

// File: tb/tb_coord_entry.sv
// Scoreboard bench for coord_entry: a 4-key/2-axis and an 8-key/3-axis instance,
// directed key sequences, expected done/err events queued and checked by a monitor.
module tb_coord_entry;

  typedef struct {
    logic [1:0]  kind;
    logic [15:0] coord;
    logic [15:0] axis;
  } exp_t;

  localparam logic [1:0] EV_DONE = 2'b10;
  localparam logic [1:0] EV_ERR  = 2'b01;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea;
  exp_t eb;

  coord_entry_if #(.NKEYS(4), .NAXES(2)) ifa ();
  coord_entry_if #(.NKEYS(8), .NAXES(3)) ifb ();

  coord_entry #(.NKEYS(4), .NAXES(2), .DEBOUNCE(4)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  coord_entry #(.NKEYS(8), .NAXES(3), .DEBOUNCE(4)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic applyStimulus(input int sel, input logic s, input logic ab,
                               input logic [7:0] k, input int n);
    for (int i = 0; i < n; i++) begin
      if (sel == 0) begin
        ifa.start = s;
        ifa.abort = ab;
        ifa.keys  = k[3:0];
      end else begin
        ifb.start = s;
        ifb.abort = ab;
        ifb.keys  = k;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pushExp(input int sel, input logic [1:0] kind,
                         input logic [15:0] c, input logic [15:0] ax);
    exp_t e;
    e.kind  = kind;
    e.coord = c;
    e.axis  = ax;
    if (sel == 0) qa.push_back(e);
    else          qb.push_back(e);
  endtask

  // Every done/err pulse must match the next queued event exactly.
  always @(negedge clk) begin
    if (ifa.done || ifa.err) begin
      if (qa.size() == 0) begin
        checkOutput("a_spurious_pulse", 16'({ifa.done, ifa.err}), 16'h0);
      end else begin
        ea = qa.pop_front();
        checkOutput("a_pulse_kind", 16'({ifa.done, ifa.err}), 16'(ea.kind));
        checkOutput("a_pulse_coord", 16'(ifa.coord), ea.coord);
        checkOutput("a_pulse_axis", 16'(ifa.axis), ea.axis);
      end
    end
    if (ifb.done || ifb.err) begin
      if (qb.size() == 0) begin
        checkOutput("b_spurious_pulse", 16'({ifb.done, ifb.err}), 16'h0);
      end else begin
        eb = qb.pop_front();
        checkOutput("b_pulse_kind", 16'({ifb.done, ifb.err}), 16'(eb.kind));
        checkOutput("b_pulse_coord", 16'(ifb.coord), eb.coord);
        checkOutput("b_pulse_axis", 16'(ifb.axis), eb.axis);
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    ifa.start = 1'b0; ifa.abort = 1'b0; ifa.keys = '0;
    ifb.start = 1'b0; ifb.abort = 1'b0; ifb.keys = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("a_reset_coord", 16'(ifa.coord), 16'h0);
    checkOutput("a_reset_axis", 16'(ifa.axis), 16'h0);
    checkOutput("a_reset_flags", 16'({ifa.busy, ifa.done, ifa.err}), 16'h0);
    checkOutput("b_reset_coord", 16'(ifb.coord), 16'h0);
    rst = 1'b1;

    $display("[TB] basic two-axis entry");
    applyStimulus(0, 1'b1, 1'b0, 8'h00, 1);
    checkOutput("a_busy_after_start", 16'(ifa.busy), 16'h1);
    applyStimulus(0, 1'b0, 1'b0, 8'h04, 6);
    checkOutput("a_field0_key2", 16'(ifa.coord), 16'h2);
    applyStimulus(0, 1'b0, 1'b0, 8'h00, 6);
    checkOutput("a_axis_advance", 16'(ifa.axis), 16'h1);
    applyStimulus(0, 1'b0, 1'b0, 8'h02, 6);
    pushExp(0, EV_DONE, 16'h6, 16'h1);
    applyStimulus(0, 1'b0, 1'b0, 8'h00, 5);
    checkOutput("a_done_cycle_flags", 16'({ifa.busy, ifa.done}), 16'h3);
    applyStimulus(0, 1'b0, 1'b0, 8'h00, 1);
    checkOutput("a_after_done_flags", 16'({ifa.busy, ifa.done}), 16'h0);
    checkOutput("a_final_coord", 16'(ifa.coord), 16'h6);

    $display("[TB] bouncing key 3, then abort");
    applyStimulus(0, 1'b1, 1'b0, 8'h00, 1);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 1'b0, 1'b0, 8'h08, 2);
      applyStimulus(0, 1'b0, 1'b0, 8'h00, 2);
    end
    checkOutput("a_no_capture_bounce", 16'(ifa.coord), 16'h6);
    applyStimulus(0, 1'b0, 1'b0, 8'h08, 5);
    checkOutput("a_field0_key3", 16'(ifa.coord), 16'h7);
    applyStimulus(0, 1'b0, 1'b0, 8'h00, 6);
    applyStimulus(0, 1'b0, 1'b0, 8'h01, 6);
    checkOutput("a_field1_key0", 16'(ifa.coord), 16'h3);
    applyStimulus(0, 1'b1, 1'b1, 8'h01, 1);
    checkOutput("a_abort_flags", 16'({ifa.busy, ifa.done}), 16'h0);
    checkOutput("a_abort_keeps_coord", 16'(ifa.coord), 16'h3);
    applyStimulus(0, 1'b0, 1'b0, 8'h00, 6);
    applyStimulus(0, 1'b1, 1'b0, 8'h00, 1);
    checkOutput("a_restart_axis", 16'(ifa.axis), 16'h0);
    checkOutput("a_restart_busy", 16'(ifa.busy), 16'h1);

    $display("[TB] multi-key rejection");
    pushExp(0, EV_ERR, 16'h3, 16'h0);
    applyStimulus(0, 1'b0, 1'b0, 8'h05, 5);
    checkOutput("a_reject_coord", 16'(ifa.coord), 16'h3);
    checkOutput("a_reject_axis", 16'(ifa.axis), 16'h0);
    applyStimulus(0, 1'b0, 1'b0, 8'h00, 6);
    applyStimulus(0, 1'b0, 1'b0, 8'h02, 6);
    checkOutput("a_retry_field0", 16'(ifa.coord), 16'h1);
    applyStimulus(0, 1'b0, 1'b0, 8'h00, 6);
    applyStimulus(0, 1'b0, 1'b0, 8'h04, 6);
    pushExp(0, EV_DONE, 16'h9, 16'h1);
    applyStimulus(0, 1'b0, 1'b0, 8'h00, 6);
    checkOutput("a_retry_final", 16'(ifa.coord), 16'h9);

    $display("[TB] asynchronous reset mid-sequence");
    applyStimulus(0, 1'b1, 1'b0, 8'h00, 1);
    applyStimulus(0, 1'b0, 1'b0, 8'h08, 6);
    checkOutput("a_pre_reset_coord", 16'(ifa.coord), 16'hB);
    #3;
    rst = 1'b0;
    #1;
    checkOutput("a_async_reset_coord", 16'(ifa.coord), 16'h0);
    checkOutput("a_async_reset_flags", 16'({ifa.busy, ifa.done, ifa.err}), 16'h0);
    checkOutput("a_async_reset_axis", 16'(ifa.axis), 16'h0);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(0, 1'b0, 1'b0, 8'h00, 6);
    applyStimulus(0, 1'b1, 1'b0, 8'h00, 1);
    applyStimulus(0, 1'b0, 1'b0, 8'h02, 6);
    applyStimulus(0, 1'b0, 1'b0, 8'h00, 6);
    applyStimulus(0, 1'b0, 1'b0, 8'h01, 6);
    pushExp(0, EV_DONE, 16'h1, 16'h1);
    applyStimulus(0, 1'b0, 1'b0, 8'h00, 6);
    checkOutput("a_post_reset_coord", 16'(ifa.coord), 16'h1);

    $display("[TB] eight keys, three axes");
    applyStimulus(1, 1'b1, 1'b0, 8'h00, 1);
    checkOutput("b_axis0", 16'(ifb.axis), 16'h0);
    applyStimulus(1, 1'b0, 1'b0, 8'h80, 6);
    checkOutput("b_field0_key7", 16'(ifb.coord), 16'h007);
    applyStimulus(1, 1'b0, 1'b0, 8'h00, 6);
    checkOutput("b_axis1", 16'(ifb.axis), 16'h1);
    applyStimulus(1, 1'b0, 1'b0, 8'h01, 6);
    checkOutput("b_field1_key0", 16'(ifb.coord), 16'h007);
    applyStimulus(1, 1'b0, 1'b0, 8'h00, 6);
    checkOutput("b_axis2", 16'(ifb.axis), 16'h2);
    applyStimulus(1, 1'b0, 1'b0, 8'h20, 6);
    pushExp(1, EV_DONE, 16'h147, 16'h2);
    applyStimulus(1, 1'b0, 1'b0, 8'h00, 6);
    checkOutput("b_final_coord", 16'(ifb.coord), 16'h147);
    checkOutput("b_axis_hold", 16'(ifb.axis), 16'h2);
    checkOutput("b_idle_busy", 16'(ifb.busy), 16'h0);

    applyStimulus(0, 1'b0, 1'b0, 8'h00, 2);
    checkOutput("a_events_pending", 16'(qa.size()), 16'h0);
    checkOutput("b_events_pending", 16'(qb.size()), 16'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
